pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Consumes the MEM-stage redirect (PCSrc), the EX-stage load-use condition, and the instruction/data memory ready handshakes.
- Drives the PC and every pipeline-register enable/flush.
- Tracks data-memory wait cycles with a timeout FSM and keeps saturating performance counters.

Parameters:
- DMEM_TIMEOUT, 16, max consecutive DWAIT cycles before bus_err pulses (must be >=2).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PCSrc_Mem  in  1  redirect taken in MEM (branch/branchN/jump resolved).
- MemRead_Ex  in  1  instruction in EX is a load.
- rd_Ex  in  5  destination register of EX instruction.
- rs1_Id, rs2_Id  in  5 each  source registers of ID instruction.
- rs1_used_Id, rs2_used_Id  in  1 each  source actually read by ID instruction.
- dmem_req_Mem  in  1  MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes access this cycle.
- imem_ready  in  1  fetch data valid this cycle.
- PC_en  out  1  PC register load enable.
- IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  pipeline-register enables.
- IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush  out  1 each  load bubble (NOP, all control zero).
- bus_err  out  1  one-cycle pulse on DMEM timeout.
- stall_cnt  out  CNT_W  cycles with PC_en=0.
- flush_cnt  out  CNT_W  count of redirects applied.

Behaviour:
- Conditions, all evaluated combinationally each cycle:
  - dwait = dmem_req_Mem & ~dmem_ready.
  - redirect = PCSrc_Mem.
  - lu = MemRead_Ex & rd_Ex!=0 & ((rs1_used_Id & rs1_Id==rd_Ex) | (rs2_used_Id & rs2_Id==rd_Ex)).
  - ifwait = ~imem_ready.
- Priority: dwait > redirect > lu > ifwait. Default: all enables=1, all flushes=0.
- dwait (state RUN or DWAIT, timeout not reached): PC_en=IFID_en=IDEX_en=EXMEM_en=0; MEMWB_flush=1. Redirect is held and applied on the cycle dmem_ready rises, since PCSrc_Mem remains stable while MEM is frozen.
- redirect: PC_en=1; IFID_flush=IDEX_flush=EXMEM_flush=1 (three younger instructions killed). MEM/WB advances. Overrides lu and ifwait.
- lu: PC_en=IFID_en=0; IDEX_flush=1. Exactly one bubble per load-use occurrence, with no state needed: the next cycle the load is in MEM and lu is false.
- ifwait: PC_en=0; IFID_flush=1; older stages advance.
- Flush dominates enable for the same register; a flushed register must have en=1.
- FSM states: RUN, DWAIT, ERR.
  - RUN -> DWAIT when dwait.
  - DWAIT -> RUN when dmem_ready.
  - DWAIT -> ERR when the wait counter reaches DMEM_TIMEOUT-1 with dmem_ready still 0.
  - ERR: lasts one cycle. bus_err=1; behaves as if the access completed (freeze released, MEMWB_flush=1). Then -> RUN.
- wait_cnt: reset to 0 on entry to DWAIT; increments each DWAIT cycle.
- stall_cnt: increments every cycle PC_en=0. flush_cnt: increments every cycle the redirect flush is applied. Both saturate at all-ones and never wrap.
- Reset:
  - State=RUN, counters=0, bus_err=0.
  - During rst=1, all enables=1 and all flushes=1 so the pipeline registers clear.
  - rst mid-DWAIT abandons the wait immediately; no bus_err.
- Latency: all stall/flush outputs are combinational the same cycle; bus_err, the counters and state are registered.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, DWAIT=2'd1, ERR=2'd2) and the NOP/bubble control constant used by the pipeline registers.
- One sub-module: sat_counter (CNT_W, inc, rst), instantiated twice.

Test Plan:
- Reset: rst=1 for 2 cycles -> all flushes=1, stall_cnt=flush_cnt=0; release -> all enables=1, flushes=0.
- Load-use: MemRead_Ex=1, rd_Ex=5, rs1_Id=5, rs1_used_Id=1 -> one cycle with PC_en=0, IFID_en=0, IDEX_flush=1; next cycle normal; stall_cnt=1. Repeat with rd_Ex=0 -> no stall.
- Redirect: PCSrc_Mem=1 for 1 cycle -> IFID/IDEX/EXMEM_flush=1, PC_en=1; flush_cnt=1. Simultaneous lu -> redirect wins, no IDEX-only stall.
- DMEM wait with held redirect: dmem_req_Mem=1, dmem_ready=0 for 3 cycles while PCSrc_Mem=1 -> 3 frozen cycles with MEMWB_flush=1, then on dmem_ready=1 the redirect flushes are applied; stall_cnt=3, flush_cnt=1.
- Timeout: DMEM_TIMEOUT=4, dmem_ready held 0 -> bus_err pulses exactly once after 4 wait cycles; FSM returns to RUN; asserting rst mid-wait instead -> no bus_err.
- Saturation: CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: DMEM wait FSM encoding, the bubble
// control word loaded by flushed pipeline registers, and the load-use compare.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_ERR   = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_n;
        logic       jump;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
    } pipe_ctrl_t;

    // A flushed register loads this: nothing writes, nothing redirects.
    localparam pipe_ctrl_t NOP_CTRL = '0;

    function automatic logic load_use_hit(
        input logic       mem_read_ex,
        input logic [4:0] rd_ex,
        input logic [4:0] rs1_id,
        input logic       rs1_used_id,
        input logic [4:0] rs2_id,
        input logic       rs2_used_id
    );
        return mem_read_ex && (rd_ex != 5'd0) &&
               ((rs1_used_id && (rs1_id == rd_ex)) ||
                (rs2_used_id && (rs2_id == rd_ex)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat.sv
// Saturating up-counter: sticks at all-ones, cleared by synchronous reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; enables/flushes are combinational,
// the DMEM timeout FSM, bus_err and performance counters are registered.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrc_Mem,
    input  logic             MemRead_Ex,
    input  logic [4:0]       rd_Ex,
    input  logic [4:0]       rs1_Id,
    input  logic [4:0]       rs2_Id,
    input  logic             rs1_used_Id,
    input  logic             rs2_used_Id,
    input  logic             dmem_req_Mem,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             MEMWB_flush,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WCW       = $clog2(DMEM_TIMEOUT);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(DMEM_TIMEOUT - 1);

    hz_state_e      state_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           bus_err_q;

    logic dwait, redirect, lu, ifwait, freeze, redirect_apply;

    assign dwait    = dmem_req_Mem && !dmem_ready;
    assign redirect = PCSrc_Mem;
    assign lu       = load_use_hit(MemRead_Ex, rd_Ex, rs1_Id, rs1_used_Id,
                                   rs2_Id, rs2_used_Id);
    assign ifwait   = !imem_ready;

    // The ERR cycle releases the freeze even if the memory is still not ready.
    assign freeze         = dwait && (state_q != ST_ERR);
    assign redirect_apply = !rst && !freeze && redirect;

    always_comb begin
        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IDEX_en     = 1'b1;
        EXMEM_en    = 1'b1;
        MEMWB_en    = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        MEMWB_flush = 1'b0;
        if (rst) begin
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            MEMWB_flush = 1'b1;
        end else if (freeze) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWB_flush = 1'b1;
        end else begin
            if (redirect) begin
                IFID_flush  = 1'b1;
                IDEX_flush  = 1'b1;
                EXMEM_flush = 1'b1;
            end else if (lu) begin
                PC_en      = 1'b0;
                IFID_en    = 1'b0;
                IDEX_flush = 1'b1;
            end else if (ifwait) begin
                PC_en      = 1'b0;
                IFID_flush = 1'b1;
            end
            // A timed-out access must not reach WB.
            if (state_q == ST_ERR) begin
                MEMWB_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (dwait) begin
                        state_q    <= ST_DWAIT;
                        wait_cnt_q <= '0;
                    end
                end
                ST_DWAIT: begin
                    if (!dwait) begin
                        state_q <= ST_RUN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q   <= ST_ERR;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                ST_ERR:  state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus_err = bus_err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (!PC_en),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (redirect_apply),
        .cnt_o (flush_cnt)
    );

endmodule
